npu_result_packer: RTL

- Downstream stage of the NPU PE array: snapshots the N signed W_ACC-bit accumulator results on a capture handshake.
- Requantizes each result to signed DATA_WIDTH: optional ReLU, rounding arithmetic right shift, then saturation.
- Packs four bytes per 32-bit word into a small output FIFO.
- The FIFO is drained by the memory-mapped read path, one word per pop.

---
 rtl/npu_result_packer_if.sv | 38 +++
 rtl/npu_result_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/npu_result_packer_if.sv
// Handshake and read-path bundle for npu_result_packer.
//   master: producer/reader side (drives capture inputs and pop)
//   slave : packer side (drives ready, FIFO head/valid/count, done)
// Signals:
//   cap_valid_i/cap_ready_o : capture handshake
//   acc_i                   : N signed accumulators, PE i at [i*W_ACC +: W_ACC]
//   shift_i, relu_en_i      : requantization controls sampled at capture
//   rd_pop_i                : pop FIFO head
//   rd_data_o, rd_valid_o   : FIFO head word and non-empty flag
//   fifo_count_o            : words held
//   done_o                  : pulse when the last word of a capture is pushed
interface npu_result_packer_if #(
  parameter int N          = 10,
  parameter int W_ACC      = 24,
  parameter int AXI_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          cap_valid_i;
  logic                          cap_ready_o;
  logic [N*W_ACC-1:0]            acc_i;
  logic [4:0]                    shift_i;
  logic                          relu_en_i;
  logic                          rd_pop_i;
  logic [AXI_WIDTH-1:0]          rd_data_o;
  logic                          rd_valid_o;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;
  logic                          done_o;

  modport master (
    output cap_valid_i, acc_i, shift_i, relu_en_i, rd_pop_i,
    input  cap_ready_o, rd_data_o, rd_valid_o, fifo_count_o, done_o
  );

  modport slave (
    input  cap_valid_i, acc_i, shift_i, relu_en_i, rd_pop_i,
    output cap_ready_o, rd_data_o, rd_valid_o, fifo_count_o, done_o
  );
endinterface

// File: rtl/npu_result_packer.sv
// Snapshots N accumulator results, requantizes each to a signed byte
// (optional ReLU, round-half-up arithmetic shift, saturation), packs four
// bytes per word little-endian and queues the words in a small FIFO that
// the read path drains one word per pop.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : npu_result_packer_if.slave (capture handshake + read path)
module npu_result_packer #(
  parameter int N          = 10,
  parameter int W_ACC      = 24,
  parameter int DATA_WIDTH = 8,
  parameter int AXI_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  npu_result_packer_if.slave bus
);
  localparam int LANES   = AXI_WIDTH / DATA_WIDTH;
  localparam int LANE_W  = $clog2(LANES);
  localparam int E_W     = $clog2(N + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ACC_X_W = W_ACC + 1;
  localparam logic [4:0] SHIFT_MAX = 5'(W_ACC - 1);
  localparam logic signed [ACC_X_W-1:0] SAT_MAX =
    ACC_X_W'((32'sd1 <<< (DATA_WIDTH - 1)) - 32'sd1);
  localparam logic signed [ACC_X_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  // One extra bit of headroom so the rounding add cannot overflow.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic signed [W_ACC-1:0] acc,
    input logic [4:0]              sh,
    input logic                    relu
  );
    logic signed [ACC_X_W-1:0] x;
    logic signed [ACC_X_W-1:0] half;
    x = {acc[W_ACC-1], acc};
    if (relu && x[ACC_X_W-1]) x = '0;
    else                      x = x;
    if (sh != 5'd0) begin
      half = ACC_X_W'(1'b1) << (sh - 5'd1);
      x    = (x + half) >>> sh;
    end else begin
      x = x;
    end
    if (x > SAT_MAX)      x = SAT_MAX;
    else if (x < SAT_MIN) x = SAT_MIN;
    else                  x = x;
    requant = x[DATA_WIDTH-1:0];
  endfunction

  state_t                     state_r;
  logic                       cap_ready_r;
  logic                       done_r;
  logic                       relu_r;
  logic [N*W_ACC-1:0]         acc_r;
  logic [4:0]                 shift_r;
  logic [E_W-1:0]             elem_r;
  logic [LANE_W-1:0]          lane_r;
  logic [AXI_WIDTH-1:0]       pack_r;
  logic [AXI_WIDTH-1:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic [AXI_WIDTH-1:0]       head_r;
  logic                       valid_r;

  logic signed [W_ACC-1:0]    elem_s;
  logic [DATA_WIDTH-1:0]      q_s;
  logic                       full_s;
  logic                       pop_s;
  logic                       push_s;
  logic [4:0]                 shift_clamp_s;
  logic [CNT_W-1:0]           count_next_s;
  logic [AXI_WIDTH-1:0]       head_next_s;

  // Select the snapshot element currently being packed.
  always_comb begin
    elem_s = '0;
    for (int i = 0; i < N; i++) begin
      elem_s = (elem_r == E_W'(i)) ? acc_r[i*W_ACC +: W_ACC] : elem_s;
    end
  end

  assign q_s = requant(elem_s, shift_r, relu_r);

  // Handshake qualifiers; a push may proceed into a full FIFO when a pop frees a slot.
  always_comb begin
    full_s        = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s         = bus.rd_pop_i && (count_r != '0);
    push_s        = (state_r == ST_PUSH) && (!full_s || pop_s);
    shift_clamp_s = (bus.shift_i > SHIFT_MAX) ? SHIFT_MAX : bus.shift_i;
  end

  // Next FIFO occupancy and next head word.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1'b1);
      2'b01:   count_next_s = count_r - CNT_W'(1'b1);
      default: count_next_s = count_r;
    endcase
    // Popping the last word hands the head straight to a same-cycle push.
    if (pop_s) begin
      if (count_r == CNT_W'(1'b1)) head_next_s = push_s ? pack_r : '0;
      else                         head_next_s = mem_r[rd_ptr_r + PTR_W'(1'b1)];
    end else if (count_r == '0) begin
      head_next_s = push_s ? pack_r : '0;
    end else begin
      head_next_s = head_r;
    end
  end

  // Capture / pack / push state machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cap_ready_r <= 1'b0;
      done_r      <= 1'b0;
      relu_r      <= 1'b0;
      acc_r       <= '0;
      shift_r     <= 5'd0;
      elem_r      <= '0;
      lane_r      <= '0;
      pack_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.cap_valid_i && cap_ready_r) begin
            acc_r       <= bus.acc_i;
            shift_r     <= shift_clamp_s;
            relu_r      <= bus.relu_en_i;
            elem_r      <= '0;
            lane_r      <= '0;
            pack_r      <= '0;
            cap_ready_r <= 1'b0;
            state_r     <= ST_PACK;
          end else begin
            cap_ready_r <= 1'b1;
          end
        end
        ST_PACK: begin
          pack_r[lane_r*DATA_WIDTH +: DATA_WIDTH] <= q_s;
          elem_r <= elem_r + E_W'(1'b1);
          lane_r <= lane_r + LANE_W'(1'b1);
          if ((lane_r == LANE_W'(LANES - 1)) || (elem_r == E_W'(N - 1))) state_r <= ST_PUSH;
          else                                                           state_r <= ST_PACK;
        end
        ST_PUSH: begin
          if (push_s) begin
            pack_r <= '0;
            if (elem_r == E_W'(N)) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_PACK;
            end
          end else begin
            state_r <= ST_PUSH;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cap_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Output FIFO storage, pointers and registered head/valid/count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= pack_r;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      else       rd_ptr_r <= rd_ptr_r;
      count_r <= count_next_s;
      head_r  <= head_next_s;
      valid_r <= (count_next_s != '0);
    end
  end

  assign bus.cap_ready_o  = cap_ready_r;
  assign bus.done_o       = done_r;
  assign bus.rd_data_o    = head_r;
  assign bus.rd_valid_o   = valid_r;
  assign bus.fifo_count_o = count_r;
endmodule
